shift_reg_unit: RTL

SHIFT_REG_UNIT -- requirements
Module: shift_reg_unit

---
 rtl/shift_reg_unit_pkg.sv | 14 +
 rtl/shift_reg_unit_step.sv | 25 ++
 rtl/shift_reg_unit.sv | 93 +++++++++
 3 files changed

// File: rtl/shift_reg_unit_pkg.sv
// Shared constants for the multi-cycle shift unit: operation encodings and
// default datapath sizing.
package shift_reg_unit_pkg;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_SHAMT_W = 5;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;

endpackage : shift_reg_unit_pkg

// File: rtl/shift_reg_unit_step.sv
// Combinational single-bit shift/rotate step used once per SHIFT cycle.
// Unassigned op codes pass the value through unchanged.
module shift_step
  import shift_reg_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_value,
  output logic [WIDTH-1:0] o_next
);

  always_comb begin
    o_next = i_value;
    case (i_op)
      OP_SLL:  o_next = {i_value[WIDTH-2:0], 1'b0};
      OP_SRL:  o_next = {1'b0, i_value[WIDTH-1:1]};
      OP_SRA:  o_next = {i_value[WIDTH-1], i_value[WIDTH-1:1]};
      OP_ROR:  o_next = {i_value[0], i_value[WIDTH-1:1]};
      OP_ROL:  o_next = {i_value[WIDTH-2:0], i_value[WIDTH-1]};
      default: o_next = i_value;
    endcase
  end

endmodule : shift_step

// File: rtl/shift_reg_unit.sv
// Iterative shifter: captures an operand on start, applies one 1-bit step per
// cycle for shamt cycles, then pulses done for a single cycle.
module shift_reg_unit
  import shift_reg_unit_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         shift_op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_data;
  logic [WIDTH-1:0]   w_data_next;
  logic [WIDTH-1:0]   w_step_out;
  logic [SHAMT_W-1:0] r_count;
  logic [SHAMT_W-1:0] w_count_next;
  logic [2:0]         r_op;
  logic [2:0]         w_op_next;

  shift_step #(
    .WIDTH(WIDTH)
  ) u_shift_step (
    .i_op   (r_op),
    .i_value(r_data),
    .o_next (w_step_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_count <= '0;
      r_op    <= OP_SLL;
    end else begin
      r_state <= w_state_next;
      r_data  <= w_data_next;
      r_count <= w_count_next;
      r_op    <= w_op_next;
    end
  end

  // start is only honoured in IDLE, so requests during SHIFT/DONE are dropped.
  always_comb begin
    w_state_next = r_state;
    w_data_next  = r_data;
    w_count_next = r_count;
    w_op_next    = r_op;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_data_next  = data_in;
          w_count_next = shamt;
          w_op_next    = shift_op;
          w_state_next = (shamt != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        w_data_next  = w_step_out;
        w_count_next = r_count - SHAMT_W'(1);
        if (r_count == SHAMT_W'(1)) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign data_out = r_data;
  assign busy     = (r_state == ST_SHIFT);
  assign done     = (r_state == ST_DONE);

endmodule : shift_reg_unit
